somador_com_sinal_pipeline: RTL and testbench

Parametrised two-stage pipelined adder/subtractor/accumulator for mixed signed and unsigned operands of independent widths. Each operand carries its own signedness flag. Overflow is detected against the output width, and the result either wraps or saturates. Sits in the datapath behind operand sources with valid/ready handshaking on both sides. It is the generalised successor to the fixed-width combinational signed/unsigned adder.

---
 rtl/somador_com_sinal_pipeline.sv | 144 ++++++++++++++
 tb/tb_somador_com_sinal_pipeline.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/somador_com_sinal_pipeline.sv
// Two-stage pipelined signed/unsigned add/sub/accumulate, latency 2, one per cycle; a stalled output holds and stalls stage 1 behind it.
// Define SATURACAO_EN to clamp overflowing results (and the accumulator) instead of wrapping them.
module somador_com_sinal_pipeline #(
    parameter int LARGURA_A = 8,
    parameter int LARGURA_B = 4,
    parameter int LARGURA_S = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 entrada_valida,
    output logic                 entrada_pronta,
    input  logic [LARGURA_A-1:0] entrada_a,
    input  logic [LARGURA_B-1:0] entrada_b,
    input  logic                 sinal_a,
    input  logic                 sinal_b,
    input  logic [1:0]           modo,
    output logic                 saida_valida,
    input  logic                 saida_pronta,
    output logic [LARGURA_S-1:0] saida,
    output logic                 estouro,
    output logic                 saida_com_sinal
);

    localparam int M_AB = (LARGURA_A > LARGURA_B) ? LARGURA_A : LARGURA_B;
    localparam int M    = (M_AB > LARGURA_S) ? M_AB : LARGURA_S;
    localparam int W    = M + 2;
    // One guard bit above W so acc+P can never wrap before the range check.
    localparam int WE   = W + 1;

    localparam logic [1:0] SOMA  = 2'b00;
    localparam logic [1:0] SUB   = 2'b01;
    localparam logic [1:0] ACUM  = 2'b10;

    localparam logic signed [WE-1:0] C_SMAX = (WE'(1) << (LARGURA_S - 1)) - WE'(1);
    localparam logic signed [WE-1:0] C_SMIN = ~C_SMAX;
    localparam logic signed [WE-1:0] C_UMAX = (WE'(1) << LARGURA_S) - WE'(1);

    logic                 r_s1_vld;
    logic [W-1:0]         r_p;
    logic [1:0]           r_s1_modo;
    logic                 r_s1_sig;
    logic                 r_s2_vld;
    logic [LARGURA_S-1:0] r_saida;
    logic                 r_estouro;
    logic                 r_sig;
    logic [LARGURA_S-1:0] r_acc;

    logic                 w_s2_load;
    logic                 w_s1_load;
    logic [W-1:0]         w_ext_a;
    logic [W-1:0]         w_ext_b;
    logic [W-1:0]         w_p;
    logic signed [WE-1:0] w_p_ext;
    logic signed [WE-1:0] w_acc_ext;
    logic signed [WE-1:0] w_e;
    logic signed [WE-1:0] w_hi;
    logic signed [WE-1:0] w_lo;
    logic                 w_acima;
    logic                 w_abaixo;
    logic [LARGURA_S-1:0] w_res;

    assign w_s2_load      = !r_s2_vld || saida_pronta;
    assign w_s1_load      = !r_s1_vld || w_s2_load;
    assign entrada_pronta = w_s1_load && !rst;

    assign w_ext_a = {{(W-LARGURA_A){sinal_a & entrada_a[LARGURA_A-1]}}, entrada_a};
    assign w_ext_b = {{(W-LARGURA_B){sinal_b & entrada_b[LARGURA_B-1]}}, entrada_b};

    always_comb begin
        w_p = '0;
        case (modo)
            SOMA, ACUM: w_p = w_ext_a + w_ext_b;
            SUB:        w_p = w_ext_a - w_ext_b;
            default:    w_p = '0;
        endcase
    end

    assign w_p_ext   = {r_p[W-1], r_p};
    assign w_acc_ext = {{(WE-LARGURA_S){r_s1_sig & r_acc[LARGURA_S-1]}}, r_acc};

    always_comb begin
        w_e = '0;
        case (r_s1_modo)
            SOMA, SUB: w_e = w_p_ext;
            ACUM:      w_e = w_acc_ext + w_p_ext;
            default:   w_e = '0;
        endcase
    end

    assign w_hi     = r_s1_sig ? C_SMAX : C_UMAX;
    assign w_lo     = r_s1_sig ? C_SMIN : '0;
    assign w_acima  = w_e > w_hi;
    assign w_abaixo = w_e < w_lo;

    always_comb begin
        w_res = w_e[LARGURA_S-1:0];
`ifdef SATURACAO_EN
        if (w_acima) begin
            w_res = w_hi[LARGURA_S-1:0];
        end else if (w_abaixo) begin
            w_res = w_lo[LARGURA_S-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_p       <= '0;
            r_s1_modo <= SOMA;
            r_s1_sig  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_saida   <= '0;
            r_estouro <= 1'b0;
            r_sig     <= 1'b0;
            r_acc     <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_vld <= entrada_valida;
                if (entrada_valida) begin
                    r_p       <= w_p;
                    r_s1_modo <= modo;
                    r_s1_sig  <= sinal_a & sinal_b;
                end
            end
            // The accumulator follows stage 2 so back-to-back ACUMs chain without a bubble.
            if (w_s2_load) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_saida   <= w_res;
                    r_estouro <= w_acima | w_abaixo;
                    r_sig     <= r_s1_sig;
                    r_acc     <= w_res;
                end
            end
        end
    end

    assign saida_valida    = r_s2_vld;
    assign saida           = r_saida;
    assign estouro         = r_estouro;
    assign saida_com_sinal = r_sig;

endmodule

// File: tb/tb_somador_com_sinal_pipeline.sv
// Scoreboard bench for somador_com_sinal_pipeline at default widths; honours SATURACAO_EN.
module tb_somador_com_sinal_pipeline;

    typedef struct packed {
        logic [7:0] val;
        logic       ovf;
        logic       sgn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       entrada_valida;
    logic       entrada_pronta;
    logic [7:0] entrada_a;
    logic [3:0] entrada_b;
    logic       sinal_a;
    logic       sinal_b;
    logic [1:0] modo;
    logic       saida_valida;
    logic       saida_pronta = 1'b1;
    logic [7:0] saida;
    logic       estouro;
    logic       saida_com_sinal;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic [7:0] m_acc = 8'h00;
    bit   rand_bp = 1'b0;
    bit   force_pronta = 1'b1;

`ifdef SATURACAO_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    somador_com_sinal_pipeline dut (
        .clk             (clk),
        .rst             (rst),
        .entrada_valida  (entrada_valida),
        .entrada_pronta  (entrada_pronta),
        .entrada_a       (entrada_a),
        .entrada_b       (entrada_b),
        .sinal_a         (sinal_a),
        .sinal_b         (sinal_b),
        .modo            (modo),
        .saida_valida    (saida_valida),
        .saida_pronta    (saida_pronta),
        .saida           (saida),
        .estouro         (estouro),
        .saida_com_sinal (saida_com_sinal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        saida_pronta = rand_bp ? ($urandom_range(0, 3) != 0) : force_pronta;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: exact integer result from the operand values, then range/clamp rules.
    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b,
                                   input logic sa, input logic sb, input logic [1:0] md);
        int   ea, eb, av, e, lo, hi;
        exp_t r;
        ea = sa ? int'($signed(a)) : int'(a);
        eb = sb ? int'($signed(b)) : int'(b);
        r.sgn = sa & sb;
        av = r.sgn ? int'($signed(m_acc)) : int'(m_acc);
        case (md)
            2'd0:    e = ea + eb;
            2'd1:    e = ea - eb;
            2'd2:    e = av + ea + eb;
            default: e = 0;
        endcase
        lo = r.sgn ? -128 : 0;
        hi = r.sgn ? 127 : 255;
        r.ovf = (e < lo) || (e > hi);
        r.val = e[7:0];
        if (SAT && e > hi) r.val = hi[7:0];
        if (SAT && e < lo) r.val = lo[7:0];
        m_acc = r.val;
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] a, input logic [3:0] b, input logic sa, input logic sb,
                        input logic [1:0] md, input bit use_exp, input exp_t ex);
        int   n;
        exp_t m;
        entrada_a = a; entrada_b = b; sinal_a = sa; sinal_b = sb; modo = md;
        entrada_valida = 1'b1;
        #1;
        n = 0;
        while (!entrada_pronta && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!entrada_pronta) begin
            checks++; errors++;
            $display("FAIL send_timeout: entrada_pronta stuck at 0, expected 1");
        end else begin
            m = model(a, b, sa, sb, md);
            q.push_back(use_exp ? ex : m);
        end
        @(negedge clk);
        entrada_valida = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (saida_valida && saida_pronta && !rst) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %0h with empty scoreboard, expected none", saida);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("saida", saida, e.val);
                check("estouro", estouro, e.ovf);
                check("saida_com_sinal", saida_com_sinal, e.sgn);
            end
        end
    end

    initial begin
        exp_t nx;
        nx = '0;
        rst = 1'b1; entrada_valida = 1'b0; entrada_a = '0; entrada_b = '0;
        sinal_a = 1'b0; sinal_b = 1'b0; modo = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check("rst_saida_valida", saida_valida, 0);
        check("rst_saida", saida, 0);
        check("rst_estouro", estouro, 0);
        check("rst_saida_com_sinal", saida_com_sinal, 0);
        check("rst_entrada_pronta", entrada_pronta, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_entrada_pronta", entrada_pronta, 1);
        @(negedge clk);

        send(8'hF6, 4'h3, 1, 1, 2'd0, 1, '{8'hF9, 1'b1 ^ 1'b1, 1'b1});
        send(8'd250, 4'd15, 0, 0, 2'd0, 1, '{SAT ? 8'hFF : 8'h09, 1'b1, 1'b0});
        send(8'd200, 4'hF, 0, 1, 2'd0, 1, '{8'd199, 1'b0, 1'b0});
        send(8'd0, 4'hF, 0, 1, 2'd0, 1, '{SAT ? 8'h00 : 8'hFF, 1'b1, 1'b0});
        send(8'd0, 4'd0, 1, 1, 2'd3, 1, '{8'h00, 1'b0, 1'b1});
        send(8'd100, 4'd0, 1, 1, 2'd2, 1, '{8'd100, 1'b0, 1'b1});
        send(8'd100, 4'd0, 1, 1, 2'd2, 1, '{SAT ? 8'h7F : 8'hC8, 1'b1, 1'b1});
        wait_empty("drain_directed");

        #1 force_pronta = 1'b0;
        @(negedge clk);
        send(8'd1, 4'd1, 0, 0, 2'd0, 1, '{8'd2, 1'b0, 1'b0});
        send(8'd2, 4'd1, 0, 0, 2'd0, 1, '{8'd3, 1'b0, 1'b0});
        entrada_a = 8'd3; entrada_b = 4'd1; sinal_a = 0; sinal_b = 0; modo = 2'd0;
        entrada_valida = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_entrada_pronta", entrada_pronta, 0);
            check("stall_saida_valida", saida_valida, 1);
            check("stall_saida", saida, 8'd2);
            @(negedge clk);
        end
        #1 force_pronta = 1'b1;
        @(negedge clk);
        send(8'd3, 4'd1, 0, 0, 2'd0, 1, '{8'd4, 1'b0, 1'b0});
        send(8'd4, 4'd1, 0, 0, 2'd0, 1, '{8'd5, 1'b0, 1'b0});
        wait_empty("drain_backpressure");

        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), 0, nx);
        end
        wait_empty("drain_random");

        rand_bp = 1'b0;
        @(negedge clk);
        send(8'd10, 4'd1, 1, 1, 2'd2, 0, nx);
        send(8'd20, 4'd1, 1, 1, 2'd2, 0, nx);
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        m_acc = 8'h00;
        rst = 1'b0;
        #1;
        check("post_rst_saida_valida", saida_valida, 0);
        @(negedge clk);
        send(8'd5, 4'd0, 1, 1, 2'd2, 1, '{8'd5, 1'b0, 1'b1});
        wait_empty("drain_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
